// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction-fetch stage. Holds the fetch PC, issues one
//            request at a time to instruction memory over req/ack, buffers
//            returned words in a small FIFO and presents them to decode
//            with valid/ready. Redirects flush the buffer and any stale
//            in-flight fetch.
// Options  : FETCH_PERF_EN adds the perf_fetched / perf_flushed counters.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter int              XLEN       = 32,
  parameter int              ADDR_W     = 12,
  parameter int              FIFO_DEPTH = 2,
  parameter logic [XLEN-1:0] RESET_PC   = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [XLEN-1:0]   imem_rdata,
  output logic              inst_valid,
  output logic [XLEN-1:0]   inst_data,
  output logic [XLEN-1:0]   inst_pc,
  input  logic              inst_ready,
  input  logic              redirect_valid,
  input  logic              redirect_sel,
  input  logic [XLEN-1:0]   redirect_pc,
  input  logic [XLEN-1:0]   redirect_rs1,
  input  logic [XLEN-1:0]   redirect_imm
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_flushed
`endif
);

  localparam int                 C_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int                 C_CNT_W = C_PTR_W + 1;
  localparam logic [C_CNT_W-1:0] C_DEPTH = C_CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_WAIT    = 2'd0,
    ST_REQ     = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [XLEN-1:0]      fetch_pc_q, fetch_pc_d;
  logic [C_PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [C_PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [C_CNT_W-1:0]   count_q, count_d;
  logic [XLEN-1:0]      fifo_pc_q   [FIFO_DEPTH];
  logic [XLEN-1:0]      fifo_pc_d   [FIFO_DEPTH];
  logic [XLEN-1:0]      fifo_data_q [FIFO_DEPTH];
  logic [XLEN-1:0]      fifo_data_d [FIFO_DEPTH];

  logic [XLEN-1:0]      w_target;
  logic                 w_push;
  logic                 w_pop;
  logic [C_CNT_W-1:0]   w_count_next;

  // Redirect target, push/pop qualifiers and post-update occupancy.
  // A redirect suppresses both push and pop: the whole buffer is stale.
  always_comb begin
    w_target     = (redirect_sel ? redirect_rs1 : redirect_pc) + redirect_imm;
    w_push       = (state_q == ST_REQ) && imem_ack && !redirect_valid;
    w_pop        = (count_q != '0) && inst_ready && !redirect_valid;
    w_count_next = count_q + C_CNT_W'(w_push) - C_CNT_W'(w_pop);
  end

  // Fetch FSM next-state and fetch PC update.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    case (state_q)
      ST_WAIT: begin
        if (redirect_valid) begin
          fetch_pc_d = w_target;
          state_d    = ST_REQ;
        end else if (count_q < C_DEPTH) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (redirect_valid) begin
          fetch_pc_d = w_target;
          // An ack in the redirect cycle retires the stale request, so the
          // new target can be requested straight away.
          state_d    = imem_ack ? ST_REQ : ST_DISCARD;
        end else if (imem_ack) begin
          fetch_pc_d = fetch_pc_q + XLEN'(1);
          state_d    = (w_count_next < C_DEPTH) ? ST_REQ : ST_WAIT;
        end
      end
      ST_DISCARD: begin
        if (redirect_valid) begin
          fetch_pc_d = w_target;
        end
        // The stale request retires on its ack even when another redirect
        // lands in the same cycle; waiting longer would never see an ack.
        if (imem_ack) begin
          state_d = ST_REQ;
        end
      end
      default: begin
        state_d = ST_WAIT;
      end
    endcase
  end

  // Instruction buffer pointers, occupancy and storage.
  always_comb begin
    fifo_pc_d   = fifo_pc_q;
    fifo_data_d = fifo_data_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (redirect_valid) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (w_push) begin
        fifo_pc_d[wr_ptr_q]   = fetch_pc_q;
        fifo_data_d[wr_ptr_q] = imem_rdata;
        wr_ptr_d              = wr_ptr_q + C_PTR_W'(1);
      end
      if (w_pop) begin
        rd_ptr_d = rd_ptr_q + C_PTR_W'(1);
      end
      count_d = w_count_next;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_WAIT;
      fetch_pc_q  <= RESET_PC;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      fifo_pc_q   <= '{default: '0};
      fifo_data_q <= '{default: '0};
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      fifo_pc_q   <= fifo_pc_d;
      fifo_data_q <= fifo_data_d;
    end
  end

  // Memory-side and decode-side outputs; head fields read as zero when empty.
  always_comb begin
    imem_req   = (state_q == ST_REQ);
    imem_addr  = fetch_pc_q[ADDR_W-1:0];
    inst_valid = (count_q != '0);
    inst_data  = inst_valid ? fifo_data_q[rd_ptr_q] : '0;
    inst_pc    = inst_valid ? fifo_pc_q[rd_ptr_q]   : '0;
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_flushed_q, perf_flushed_d;
  logic        w_drop_ack;
  logic [32:0] w_fetched_sum;
  logic [32:0] w_flushed_sum;

  // Saturating event counters: pushes, and dropped acks plus flushed entries.
  always_comb begin
    w_drop_ack     = imem_ack && (((state_q == ST_REQ) && redirect_valid) ||
                                  (state_q == ST_DISCARD));
    w_fetched_sum  = {1'b0, perf_fetched_q} + 33'(w_push);
    w_flushed_sum  = {1'b0, perf_flushed_q} + 33'(w_drop_ack) +
                     (redirect_valid ? 33'(count_q) : 33'd0);
    perf_fetched_d = w_fetched_sum[32] ? 32'hFFFF_FFFF : w_fetched_sum[31:0];
    perf_flushed_d = w_flushed_sum[32] ? 32'hFFFF_FFFF : w_flushed_sum[31:0];
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetched_q <= '0;
      perf_flushed_q <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_flushed_q <= perf_flushed_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_flushed = perf_flushed_q;
`endif

endmodule
`default_nettype wire
